dla_hld_lsu_read_decoalescer: RTL



---
 rtl/dla_hld_lsu_read_decoalescer_pkg.sv | 26 ++
 rtl/dla_hld_lsu_read_decoalescer_if.sv | 34 +++
 rtl/dla_hld_lsu_decoalescer_meta_fifo.sv | 68 ++++++
 rtl/dla_hld_lsu_read_decoalescer.sv | 96 +++++++++
 4 files changed

// File: rtl/dla_hld_lsu_read_decoalescer_pkg.sv
// Shared LSU read-path definitions: lane geometry helpers and the coalescer-to-decoalescer
// metadata record.
package dla_hld_lsu_read_decoalescer_pkg;

  localparam int LSU_DATA_WIDTH     = 32;
  localparam int LSU_MEM_DATA_WIDTH = 512;
  localparam int LSU_META_DEPTH     = 8;

  function automatic int dla_lsu_wpm(input int dw, input int mdw);
    return mdw / dw;
  endfunction

  // A single-lane memory word still carries a 1-bit offset so the field never vanishes.
  function automatic int dla_lsu_offset_w(input int dw, input int mdw);
    return (mdw / dw > 1) ? $clog2(mdw / dw) : 1;
  endfunction

  localparam int LSU_WPM      = dla_lsu_wpm(LSU_DATA_WIDTH, LSU_MEM_DATA_WIDTH);
  localparam int LSU_OFFSET_W = dla_lsu_offset_w(LSU_DATA_WIDTH, LSU_MEM_DATA_WIDTH);

  typedef struct packed {
    logic [LSU_OFFSET_W-1:0] offset;
    logic                    last;
  } dla_lsu_decoal_meta_t;

endpackage

// File: rtl/dla_hld_lsu_read_decoalescer_if.sv
// Handshake bundle of the read decoalescer: metadata in, memory words in, kernel words out.
// Signal names carry the decoalescer's own direction prefix.
interface dla_hld_lsu_read_decoalescer_if
  import dla_hld_lsu_read_decoalescer_pkg::*;
#(
  parameter int DATA_WIDTH     = LSU_DATA_WIDTH,
  parameter int MEM_DATA_WIDTH = LSU_MEM_DATA_WIDTH
) ();

  localparam int OFF_W = dla_lsu_offset_w(DATA_WIDTH, MEM_DATA_WIDTH);

  logic                      i_meta_valid;
  logic [OFF_W-1:0]          i_meta_offset;
  logic                      i_meta_last;
  logic                      o_meta_ready;
  logic                      i_mem_valid;
  logic [MEM_DATA_WIDTH-1:0] i_mem_data;
  logic                      o_mem_ready;
  logic                      o_valid;
  logic [DATA_WIDTH-1:0]     o_data;
  logic                      i_ready;
  logic                      o_idle;

  modport slave (
    input  i_meta_valid, i_meta_offset, i_meta_last, i_mem_valid, i_mem_data, i_ready,
    output o_meta_ready, o_mem_ready, o_valid, o_data, o_idle
  );

  modport master (
    output i_meta_valid, i_meta_offset, i_meta_last, i_mem_valid, i_mem_data, i_ready,
    input  o_meta_ready, o_mem_ready, o_valid, o_data, o_idle
  );

endinterface

// File: rtl/dla_hld_lsu_decoalescer_meta_fifo.sv
// Register-based metadata FIFO with registered full/empty; an entry is readable at the head
// one clock after it is pushed.
module dla_hld_lsu_decoalescer_meta_fifo
  import dla_hld_lsu_read_decoalescer_pkg::*;
#(
  parameter int DEPTH = LSU_META_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_push,
  input  dla_lsu_decoal_meta_t i_wdata,
  output logic                 o_full,
  input  logic                 i_pop,
  output dla_lsu_decoal_meta_t o_rdata,
  output logic                 o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dla_lsu_decoal_meta_t r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_d;
  logic                 r_full;
  logic                 r_empty;
  logic                 w_push;
  logic                 w_pop;

  // Gating on the registered flags means a pop at full frees the slot only next cycle.
  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_d;
      r_full  <= (w_count_d == CNT_W'(DEPTH));
      r_empty <= (w_count_d == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/dla_hld_lsu_read_decoalescer.sv
// LSU read decoalescer: holds one memory word and emits one kernel word per queued metadata
// entry, releasing the word on the entry marked last.
module dla_hld_lsu_read_decoalescer
  import dla_hld_lsu_read_decoalescer_pkg::*;
#(
  parameter int DATA_WIDTH     = LSU_DATA_WIDTH,
  parameter int MEM_DATA_WIDTH = LSU_MEM_DATA_WIDTH,
  parameter int META_DEPTH     = LSU_META_DEPTH
) (
  input logic                           clock,
  input logic                           reset,
  dla_hld_lsu_read_decoalescer_if.slave bus
);

  localparam int WPM = dla_lsu_wpm(DATA_WIDTH, MEM_DATA_WIDTH);

  dla_lsu_decoal_meta_t            w_push_entry;
  dla_lsu_decoal_meta_t            w_head;
  logic                            w_meta_full;
  logic                            w_meta_empty;
  logic                            r_hold_valid;
  logic                            w_hold_valid_d;
  logic [MEM_DATA_WIDTH-1:0]       r_hold_data;
  logic [WPM-1:0][DATA_WIDTH-1:0]  w_lanes;
  logic                            r_valid;
  logic                            w_valid_d;
  logic [DATA_WIDTH-1:0]           r_data;
  logic [DATA_WIDTH-1:0]           w_data_d;
  logic                            w_adv;
  logic                            w_release;
  logic                            w_mem_ready;
  logic                            w_mem_load;

  assign w_push_entry.offset = bus.i_meta_offset;
  assign w_push_entry.last   = bus.i_meta_last;

  dla_hld_lsu_decoalescer_meta_fifo #(
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.i_meta_valid),
    .i_wdata (w_push_entry),
    .o_full  (w_meta_full),
    .i_pop   (w_adv),
    .o_rdata (w_head),
    .o_empty (w_meta_empty)
  );

  assign w_lanes = r_hold_data;

  always_comb begin
    w_adv          = r_hold_valid & ~w_meta_empty & (~r_valid | bus.i_ready);
    w_release      = w_adv & w_head.last;
    // Releasing and reloading in one clock keeps back-to-back memory words bubble-free.
    w_mem_ready    = ~r_hold_valid | w_release;
    w_mem_load     = bus.i_mem_valid & w_mem_ready;

    w_hold_valid_d = r_hold_valid;
    if (w_mem_load) begin
      w_hold_valid_d = 1'b1;
    end else if (w_release) begin
      w_hold_valid_d = 1'b0;
    end

    w_valid_d = r_valid;
    w_data_d  = r_data;
    if (w_adv) begin
      w_valid_d = 1'b1;
      w_data_d  = w_lanes[w_head.offset];
    end else if (bus.i_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
    end else begin
      r_hold_valid <= w_hold_valid_d;
      if (w_mem_load) r_hold_data <= bus.i_mem_data;
      r_valid      <= w_valid_d;
      r_data       <= w_data_d;
    end
  end

  assign bus.o_meta_ready = ~w_meta_full;
  assign bus.o_mem_ready  = w_mem_ready;
  assign bus.o_valid      = r_valid;
  assign bus.o_data       = r_data;
  assign bus.o_idle       = w_meta_empty & ~r_hold_valid & ~r_valid;

endmodule
